// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings and defaults for the unified memory arbiter.
// State and grant codes are fixed so external probes can decode them.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

  localparam int DEF_MAX_STREAK = 4;
  localparam int DEF_TIMEOUT    = 32;

endpackage

// File: rtl/unified_mem_arbiter_arb_pick.sv
// Fetch/data winner select with a data-streak limiter
// so fetch cannot starve behind back-to-back data accesses.
module arb_pick
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic take,
  output logic gnt
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  logic [SW-1:0] streakQ;
  logic          capped;
  gnt_t          pick;

  assign capped = (streakQ == SW'(MAX_STREAK));
  assign pick   = (dm_req && !(if_req && capped)) ? GNT_DM : GNT_IF;
  assign gnt    = pick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streakQ <= '0;
    end else if (take) begin
      if (pick == GNT_DM && if_req)
        streakQ <= capped ? streakQ : streakQ + 1'b1;
      else
        streakQ <= '0;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one multi-cycle single-port memory between fetch and data ports.
// IDLE -> ISSUE -> WAIT -> DONE; every output is a register.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MAX_STREAK = DEF_MAX_STREAK,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            stateQ, stateD;
  gnt_t              gntQ, gntD;
  logic              pickGnt;
  logic              take;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic              wrQ, wrD;
  logic [DATA_W-1:0] wdataQ, wdataD;
  logic              memEnQ, memEnD;
  logic [TW-1:0]     timerQ, timerD;
  logic [DATA_W-1:0] ifRdataQ, ifRdataD;
  logic [DATA_W-1:0] dmRdataQ, dmRdataD;
  logic              ifDoneQ, ifDoneD;
  logic              dmDoneQ, dmDoneD;
  logic              errQ, errD;

  assign take = (stateQ == IDLE) && (if_req || dm_req);

  arb_pick #(
    .MAX_STREAK(MAX_STREAK)
  ) uPick (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .dm_req (dm_req),
    .take   (take),
    .gnt    (pickGnt)
  );

  always_comb begin
    stateD   = stateQ;
    gntD     = gntQ;
    addrD    = addrQ;
    wrD      = wrQ;
    wdataD   = wdataQ;
    memEnD   = memEnQ;
    timerD   = timerQ;
    ifRdataD = ifRdataQ;
    dmRdataD = dmRdataQ;
    ifDoneD  = 1'b0;
    dmDoneD  = 1'b0;
    errD     = errQ;
    unique case (stateQ)
      IDLE: begin
        if (take) begin
          gntD   = gnt_t'(pickGnt);
          addrD  = pickGnt ? dm_addr : if_addr;
          wrD    = pickGnt & dm_wr;
          wdataD = pickGnt ? dm_wdata : '0;
          memEnD = 1'b1;
          stateD = ISSUE;
        end
      end
      ISSUE: begin
        if (!mem_stall) begin
          memEnD = 1'b0;
          timerD = '0;
          stateD = WAIT;
        end
      end
      WAIT: begin
        if (mem_done) begin
          if (gntQ == GNT_IF)
            ifRdataD = mem_rdata;
          else if (!wrQ)
            dmRdataD = mem_rdata;
          ifDoneD = (gntQ == GNT_IF);
          dmDoneD = (gntQ == GNT_DM);
          stateD  = DONE;
        end else if (timerQ == TW'(TIMEOUT - 1)) begin
          // Abort: hand the core a clean zero instead of stale data.
          errD = 1'b1;
          if (gntQ == GNT_IF)
            ifRdataD = '0;
          else
            dmRdataD = '0;
          ifDoneD = (gntQ == GNT_IF);
          dmDoneD = (gntQ == GNT_DM);
          stateD  = DONE;
        end else begin
          timerD = timerQ + 1'b1;
        end
      end
      DONE: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= IDLE;
      gntQ     <= GNT_IF;
      addrQ    <= '0;
      wrQ      <= 1'b0;
      wdataQ   <= '0;
      memEnQ   <= 1'b0;
      timerQ   <= '0;
      ifRdataQ <= '0;
      dmRdataQ <= '0;
      ifDoneQ  <= 1'b0;
      dmDoneQ  <= 1'b0;
      errQ     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      gntQ     <= gntD;
      addrQ    <= addrD;
      wrQ      <= wrD;
      wdataQ   <= wdataD;
      memEnQ   <= memEnD;
      timerQ   <= timerD;
      ifRdataQ <= ifRdataD;
      dmRdataQ <= dmRdataD;
      ifDoneQ  <= ifDoneD;
      dmDoneQ  <= dmDoneD;
      errQ     <= errD;
    end
  end

  assign if_rdata  = ifRdataQ;
  assign if_done   = ifDoneQ;
  assign dm_rdata  = dmRdataQ;
  assign dm_done   = dmDoneQ;
  assign mem_en    = memEnQ;
  assign mem_wr    = wrQ;
  assign mem_addr  = addrQ;
  assign mem_wdata = wdataQ;
  assign err       = errQ;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed accesses,
// memory-side bus checks and done-side rdata/err/latency checks.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        dm_req = 1'b0;
  logic        dm_wr = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_stall = 1'b0;
  logic        mem_done = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        err;

  unified_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_stall (mem_stall),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        isDm;
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } doneExp_t;

  typedef struct {
    int          enCyc;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } issueExp_t;

  doneExp_t    doneQ[$];
  issueExp_t   issueQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] memArr [0:511];
  int          stallLeft = 0;
  bit          noDone = 1'b0;
  bit          strayReq = 1'b0;

  always @(posedge clk) cyc++;

  task automatic pushDone(input string n, input logic isDm,
                          input logic [15:0] rd, input logic e,
                          input int c);
    doneExp_t d;
    d.name = n;
    d.isDm = isDm;
    d.rdata = rd;
    d.err = e;
    d.cyc = c;
    doneQ.push_back(d);
  endtask

  task automatic pushIssue(input int c, input logic wr,
                           input logic [15:0] a, input logic [15:0] wd);
    issueExp_t x;
    x.enCyc = c;
    x.wr = wr;
    x.addr = a;
    x.wdata = wd;
    issueQ.push_back(x);
  endtask

  task automatic checkDone(input logic isDm, input logic [15:0] rd);
    doneExp_t e;
    checks++;
    if (doneQ.size() == 0) begin
      errors++;
      $display("FAIL unexpected_done: port=%0d rdata=%h cyc=%0d, required no done",
               isDm, rd, cyc);
      return;
    end
    e = doneQ.pop_front();
    if (isDm !== e.isDm || rd !== e.rdata || err !== e.err || cyc != e.cyc) begin
      errors++;
      $display("FAIL %s: got port=%0d rdata=%h err=%b cyc=%0d, required port=%0d rdata=%h err=%b cyc=%0d",
               e.name, isDm, rd, err, cyc, e.isDm, e.rdata, e.err, e.cyc);
    end
  endtask

  // Done-side monitor
  initial begin
    forever begin
      @(negedge clk);
      if (if_done) checkDone(1'b0, if_rdata);
      if (dm_done) checkDone(1'b1, dm_rdata);
    end
  end

  // Memory model with issue-side checking
  initial begin
    bit          seen;
    bit          pend;
    logic [15:0] rdNext;
    issueExp_t   x;
    seen = 1'b0;
    pend = 1'b0;
    rdNext = '0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (pend) begin
        mem_done = 1'b1;
        mem_rdata = rdNext;
        pend = 1'b0;
      end else if (strayReq) begin
        mem_done = 1'b1;
        mem_rdata = 16'hDEAD;
        strayReq = 1'b0;
      end
      if (mem_en) begin
        checks++;
        if (issueQ.size() == 0) begin
          errors++;
          $display("FAIL extra_issue: mem_en=1 addr=%h cyc=%0d, required mem_en=0",
                   mem_addr, cyc);
          mem_stall = 1'b0;
        end else begin
          x = issueQ[0];
          if (!seen && cyc != x.enCyc) begin
            errors++;
            $display("FAIL issue_cycle: got cyc=%0d, required cyc=%0d", cyc, x.enCyc);
          end
          seen = 1'b1;
          if (mem_wr !== x.wr || mem_addr !== x.addr ||
              (x.wr && mem_wdata !== x.wdata)) begin
            errors++;
            $display("FAIL issue_bus: got wr=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                     mem_wr, mem_addr, mem_wdata, x.wr, x.addr, x.wdata);
          end
          if (stallLeft > 0) begin
            mem_stall = 1'b1;
            stallLeft--;
          end else begin
            mem_stall = 1'b0;
            void'(issueQ.pop_front());
            seen = 1'b0;
            if (mem_wr) memArr[mem_addr[8:0]] = mem_wdata;
            else rdNext = memArr[mem_addr[8:0]];
            if (!noDone) pend = 1'b1;
          end
        end
      end else begin
        mem_stall = 1'b0;
      end
    end
  end

  task automatic runMix(input int nDm, input int nIf, input int budget);
    int sd;
    int si;
    sd = 0;
    si = 0;
    for (int i = 0; i < budget && (sd < nDm || si < nIf); i++) begin
      @(negedge clk);
      if (dm_done) begin
        sd++;
        if (sd >= nDm) dm_req = 1'b0;
      end
      if (if_done) begin
        si++;
        if (si >= nIf) if_req = 1'b0;
      end
    end
    checks++;
    if (sd != nDm || si != nIf) begin
      errors++;
      $display("FAIL run_budget: got dm=%0d if=%0d dones, required dm=%0d if=%0d",
               sd, si, nDm, nIf);
      dm_req = 1'b0;
      if_req = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    bit          isIf;
    for (int i = 0; i < 512; i++) memArr[i] = 16'h0;
    memArr[9'h040] = 16'hBEEF;
    memArr[9'h041] = 16'h4141;
    memArr[9'h002] = 16'h0013;
    memArr[9'h004] = 16'h0404;
    memArr[9'h006] = 16'h0606;

    repeat (3) @(negedge clk);
    checks++;
    if ({if_rdata, if_done, dm_rdata, dm_done, mem_en, mem_wr,
         mem_addr, mem_wdata, err} !== '0) begin
      errors++;
      $display("FAIL reset_state: got if_rdata=%h dm_rdata=%h mem_en=%b err=%b, required all 0",
               if_rdata, dm_rdata, mem_en, err);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait load
    pushIssue(cyc + 1, 1'b0, 16'h0040, 16'h0);
    pushDone("t1_load", 1'b1, 16'hBEEF, 1'b0, cyc + 3);
    dm_wr = 1'b0;
    dm_addr = 16'h0040;
    dm_req = 1'b1;
    runMix(1, 0, 20);

    // Collision: store first, fetch on next IDLE
    pushIssue(cyc + 1, 1'b1, 16'h0100, 16'h1234);
    pushIssue(cyc + 5, 1'b0, 16'h0002, 16'h0);
    pushDone("t2_store", 1'b1, 16'hBEEF, 1'b0, cyc + 3);
    pushDone("t2_fetch", 1'b0, 16'h0013, 1'b0, cyc + 7);
    if_addr = 16'h0002;
    dm_wr = 1'b1;
    dm_addr = 16'h0100;
    dm_wdata = 16'h1234;
    if_req = 1'b1;
    dm_req = 1'b1;
    runMix(1, 1, 30);

    // Starvation: 4 dm, 1 if, 4 dm, 1 if
    for (int k = 0; k < 10; k++) begin
      isIf = (k == 4 || k == 9);
      a = isIf ? 16'h0004 : 16'h0041;
      pushIssue(cyc + 4 * k + 1, 1'b0, a, 16'h0);
      pushDone(isIf ? "t3_if" : "t3_dm", !isIf,
               isIf ? 16'h0404 : 16'h4141, 1'b0, cyc + 4 * k + 3);
    end
    if_addr = 16'h0004;
    dm_addr = 16'h0041;
    dm_wr = 1'b0;
    dm_wdata = 16'h0;
    if_req = 1'b1;
    dm_req = 1'b1;
    runMix(8, 2, 100);

    // Backpressure: 3 stall cycles on issue
    stallLeft = 3;
    pushIssue(cyc + 1, 1'b1, 16'h0080, 16'hA5A5);
    pushDone("t4_stall", 1'b1, 16'h4141, 1'b0, cyc + 6);
    dm_wr = 1'b1;
    dm_addr = 16'h0080;
    dm_wdata = 16'hA5A5;
    dm_req = 1'b1;
    runMix(1, 0, 30);

    // Timeout on a fetch, then err stays sticky
    noDone = 1'b1;
    pushIssue(cyc + 1, 1'b0, 16'h0006, 16'h0);
    pushDone("t5_timeout", 1'b0, 16'h0000, 1'b1, cyc + 34);
    if_addr = 16'h0006;
    if_req = 1'b1;
    runMix(0, 1, 60);
    noDone = 1'b0;
    pushIssue(cyc + 1, 1'b0, 16'h0040, 16'h0);
    pushDone("t5_after", 1'b1, 16'hBEEF, 1'b1, cyc + 3);
    dm_wr = 1'b0;
    dm_addr = 16'h0040;
    dm_req = 1'b1;
    runMix(1, 0, 20);

    // Reset mid-WAIT
    noDone = 1'b1;
    pushIssue(cyc + 1, 1'b0, 16'h0002, 16'h0);
    if_addr = 16'h0002;
    if_req = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({if_rdata, if_done, dm_rdata, dm_done, mem_en, mem_wr,
         mem_addr, mem_wdata, err} !== '0) begin
      errors++;
      $display("FAIL async_reset: got if_rdata=%h dm_rdata=%h err=%b mem_en=%b, required all 0",
               if_rdata, dm_rdata, err, mem_en);
    end
    if_req = 1'b0;
    noDone = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    strayReq = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (if_rdata !== 16'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL stray_done: got if_rdata=%h err=%b, required 0000 0",
               if_rdata, err);
    end
    pushIssue(cyc + 1, 1'b0, 16'h0002, 16'h0);
    pushDone("t6_fetch", 1'b0, 16'h0013, 1'b0, cyc + 3);
    if_req = 1'b1;
    runMix(0, 1, 20);

    repeat (5) @(negedge clk);
    checks++;
    if (doneQ.size() != 0 || issueQ.size() != 0) begin
      errors++;
      $display("FAIL leftovers: got done=%0d issue=%0d pending, required 0 0",
               doneQ.size(), issueQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
